// File: rtl/mbgd_pkg.sv
// Shared defaults and FSM state encoding for the mini-batch gradient-descent theta update block.
package mbgd_pkg;

    localparam int DW_DEF       = 8;
    localparam int N_DEF        = 8;
    localparam int N_BIT_DEF    = 3;
    localparam int LR_SHIFT_DEF = 4;
    localparam int ITER_W       = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/mbgd_sat_sub.sv
// One-lane theta step: theta - (g >>> LR_SHIFT), evaluated wide and clamped to the DW-bit signed range.
module mbgd_sat_sub
    import mbgd_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int LR_SHIFT = LR_SHIFT_DEF
) (
    input  logic signed [DW-1:0]   theta_lane,
    input  logic signed [2*DW-1:0] grad,
    output logic signed [DW-1:0]   theta_next
);

    localparam int WW = 2*DW + 1;
    localparam logic signed [WW-1:0] MAX_V = WW'(2**(DW-1) - 1);
    localparam logic signed [WW-1:0] MIN_V = WW'(-(2**(DW-1)));

    logic signed [2*DW-1:0] step;
    logic signed [WW-1:0]   diff;

    assign step = grad >>> LR_SHIFT;

    // Both operands sign-extended explicitly so the subtraction can never overflow.
    assign diff = {{(DW+1){theta_lane[DW-1]}}, theta_lane} - {step[2*DW-1], step};

    // NOTE: every branch assigns theta_next, so this stays pure combinational logic with no latch.
    always_comb begin
        if (diff > MAX_V) begin
            theta_next = MAX_V[DW-1:0];
        end else if (diff < MIN_V) begin
            theta_next = MIN_V[DW-1:0];
        end else begin
            theta_next = diff[DW-1:0];
        end
    end

endmodule

// File: rtl/mbgd_theta_update.sv
// Sequential theta update: accepts one gradient component per beat, updates the matching lane
// through a single shared saturating subtractor, and pulses theta_valid once all N lanes are done.
module mbgd_theta_update
    import mbgd_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int N        = N_DEF,
    parameter int N_BIT    = N_BIT_DEF,
    parameter int LR_SHIFT = LR_SHIFT_DEF
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   enable,
    input  logic                   load,
    input  logic [DW*N-1:0]        theta_init,
    input  logic                   g_valid,
    input  logic signed [2*DW-1:0] g,
    output logic                   g_ready,
    output logic [DW*N-1:0]        theta,
    output logic                   theta_valid,
    output logic                   busy,
    output logic [ITER_W-1:0]      iter_count
);

    state_t                state_q, state_d;
    logic [N_BIT-1:0]      index_q;
    logic [N-1:0][DW-1:0]  theta_q;
    logic [ITER_W-1:0]     iter_q;

    logic                  ready_c;
    logic                  accept;
    logic                  do_load;
    logic                  leave_done;
    logic                  last_lane;
    logic signed [DW-1:0]  lane_cur;
    logic signed [DW-1:0]  lane_next;

    assign last_lane = (index_q == N_BIT'(N-1));
    assign lane_cur  = theta_q[index_q];

    mbgd_sat_sub #(
        .DW       (DW),
        .LR_SHIFT (LR_SHIFT)
    ) u_sat_sub (
        .theta_lane (lane_cur),
        .grad       (g),
        .theta_next (lane_next)
    );

    always_comb begin
        state_d    = state_q;
        ready_c    = 1'b0;
        accept     = 1'b0;
        do_load    = 1'b0;
        leave_done = 1'b0;
        if (enable) begin
            case (state_q)
                IDLE: begin
                    // A load in IDLE wins over any gradient beat offered in the same cycle.
                    if (load) begin
                        do_load = 1'b1;
                    end else begin
                        ready_c = 1'b1;
                        if (g_valid) begin
                            accept  = 1'b1;
                            state_d = last_lane ? DONE : ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    ready_c = 1'b1;
                    if (g_valid) begin
                        accept = 1'b1;
                        if (last_lane) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    state_d    = IDLE;
                    leave_done = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values, so the lane read
    // through lane_cur and the index advance happen consistently on the same edge.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            index_q <= '0;
            // NOTE: theta is a flop array, not a RAM, so clearing it on reset is cheap and drops a
            // partially updated sweep.
            theta_q <= '0;
            iter_q  <= '0;
        end else begin
            if (do_load) begin
                theta_q <= theta_init;
            end else if (accept) begin
                theta_q[index_q] <= lane_next;
                index_q          <= last_lane ? '0 : index_q + N_BIT'(1);
            end
            if (leave_done) begin
                iter_q <= iter_q + ITER_W'(1);
            end
        end
    end

    assign g_ready     = ready_c & ~resetn;
    assign theta       = theta_q;
    assign theta_valid = (state_q == DONE);
    assign busy        = (state_q == ACCUM);
    assign iter_count  = iter_q;

endmodule

// File: tb/tb_mbgd_theta_update.sv
// Self-checking bench for mbgd_theta_update: directed scenarios plus a random phase, all checked
// against a lane-counting arithmetic model of the theta update.
module tb_mbgd_theta_update;

    localparam int DW = 8;
    localparam int N  = 8;

    logic            clk = 1'b0;
    logic            resetn;
    logic            enable;
    logic            load;
    logic [DW*N-1:0] theta_init;
    logic            g_valid;
    logic [2*DW-1:0] g;
    logic            g_ready;
    logic [DW*N-1:0] theta;
    logic            theta_valid;
    logic            busy;
    logic [15:0]     iter_count;

    mbgd_theta_update dut (
        .clk         (clk),
        .resetn      (resetn),
        .enable      (enable),
        .load        (load),
        .theta_init  (theta_init),
        .g_valid     (g_valid),
        .g           (g),
        .g_ready     (g_ready),
        .theta       (theta),
        .theta_valid (theta_valid),
        .busy        (busy),
        .iter_count  (iter_count)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Model: lane values as integers, m_lane = lanes done this sweep (N means the completion cycle).
    int theta_m [N];
    int m_lane;
    int m_iter;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int upd(input int t, input logic [15:0] graw);
        int gv;
        int s;
        int d;
        gv = int'($signed(graw));
        // Floor division by 16 (alpha = 1/16), rounding toward minus infinity.
        if (gv >= 0) s = gv / 16;
        else         s = -((-gv + 15) / 16);
        d = t - s;
        if (d > 127)  d = 127;
        if (d < -128) d = -128;
        return d;
    endfunction

    function automatic logic [63:0] exp_theta();
        logic [63:0] v;
        for (int k = 0; k < N; k++) v[8*k +: 8] = theta_m[k][7:0];
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) theta_m[k] = 0;
        m_lane = 0;
        m_iter = 0;
    endtask

    task automatic check_outputs();
        chk("theta", theta, exp_theta());
        chk("theta_valid", theta_valid, 64'(m_lane == N));
        chk("busy", busy, 64'(m_lane > 0 && m_lane < N));
        chk("iter_count", iter_count, 64'(m_iter & 16'hFFFF));
    endtask

    task automatic cyc(input bit en, input bit ld, input bit gv, input logic [15:0] gval);
        enable  = en;
        load    = ld;
        g_valid = gv;
        g       = gval;
        #1;
        chk("g_ready", g_ready, 64'(en && m_lane < N && !(ld && m_lane == 0)));
        @(posedge clk);
        if (en) begin
            if (m_lane == 0 && ld) begin
                for (int k = 0; k < N; k++) theta_m[k] = int'($signed(theta_init[8*k +: 8]));
            end else if (m_lane == N) begin
                m_lane = 0;
                m_iter++;
            end else if (gv) begin
                theta_m[m_lane] = upd(theta_m[m_lane], gval);
                m_lane++;
            end
        end
        #1;
        check_outputs();
    endtask

    logic [15:0] gs [N];
    logic [63:0] ref_theta;
    int          tv_cnt;
    int          iter_before;

    initial begin
        resetn     = 1'b1;
        enable     = 1'b1;
        load       = 1'b0;
        g_valid    = 1'b1;
        g          = 16'h0040;
        theta_init = '1;
        model_reset();

        // Reset state while reset is held.
        #3;
        chk("rst_theta", theta, 64'h0);
        chk("rst_theta_valid", theta_valid, 64'h0);
        chk("rst_busy", busy, 64'h0);
        chk("rst_g_ready", g_ready, 64'h0);
        chk("rst_iter", iter_count, 64'h0);
        @(posedge clk);
        #1;
        resetn = 1'b0;

        // Basic sweep: all lanes 0x10, g = 0x0040 -> 0x0C each.
        theta_init = {8{8'h10}};
        cyc(1, 1, 0, 16'h0);
        for (int k = 0; k < N; k++) begin
            cyc(1, 0, 1, 16'h0040);
            chk("basic_tv_timing", theta_valid, 64'(k == N-1));
        end
        chk("basic_theta", theta, {8{8'h0C}});
        cyc(1, 0, 0, 16'h0);
        chk("basic_iter", iter_count, 64'd1);

        // Saturation at both ends of the range.
        theta_init = {$urandom, $urandom};
        theta_init[15:0] = 16'h7F80;
        cyc(1, 1, 0, 16'h0);
        cyc(1, 0, 1, 16'h7FF0);
        chk("sat_low_lane0", theta[7:0], 64'h80);
        cyc(1, 0, 1, 16'h8000);
        chk("sat_high_lane1", theta[15:8], 64'h7F);
        for (int k = 2; k < N; k++) cyc(1, 0, 1, 16'($urandom));
        cyc(1, 0, 0, 16'h0);

        // Backpressure: a stalled sweep must end identical to an unstalled one.
        theta_init = {$urandom, $urandom};
        for (int k = 0; k < N; k++) gs[k] = 16'($urandom);
        cyc(1, 1, 0, 16'h0);
        for (int k = 0; k < N; k++) cyc(1, 0, 1, gs[k]);
        ref_theta = exp_theta();
        cyc(1, 0, 0, 16'h0);
        cyc(1, 1, 0, 16'h0);
        for (int k = 0; k < 4; k++) cyc(1, 0, 1, gs[k]);
        for (int s = 0; s < 5; s++) begin
            cyc(1, 0, 0, 16'($urandom));
            chk("stall_busy", busy, 64'h1);
        end
        for (int k = 4; k < N; k++) cyc(1, 0, 1, gs[k]);
        chk("stall_same_theta", theta, ref_theta);
        cyc(1, 0, 0, 16'h0);

        // enable low while in DONE: completion pulse stretches, one iteration counted.
        iter_before = m_iter;
        for (int k = 0; k < N; k++) cyc(1, 0, 1, 16'($urandom));
        tv_cnt = (theta_valid === 1'b1) ? 1 : 0;
        for (int s = 0; s < 3; s++) begin
            cyc(0, $urandom_range(0, 1) == 1, 1, 16'($urandom));
            if (theta_valid === 1'b1) tv_cnt++;
        end
        cyc(1, 0, 0, 16'h0);
        if (theta_valid === 1'b1) tv_cnt++;
        chk("done_hold_cycles", 64'(tv_cnt), 64'd4);
        chk("done_hold_iter", iter_count, 64'(iter_before + 1));

        // Asynchronous reset mid-sweep, then a fresh sweep from zero.
        theta_init = {$urandom, $urandom};
        cyc(1, 1, 0, 16'h0);
        for (int k = 0; k < 5; k++) cyc(1, 0, 1, 16'($urandom));
        #1;
        resetn = 1'b1;
        #1;
        chk("midrst_theta", theta, 64'h0);
        chk("midrst_busy", busy, 64'h0);
        chk("midrst_theta_valid", theta_valid, 64'h0);
        chk("midrst_g_ready", g_ready, 64'h0);
        chk("midrst_iter", iter_count, 64'h0);
        model_reset();
        @(posedge clk);
        #1;
        resetn = 1'b0;
        for (int k = 0; k < N; k++) cyc(1, 0, 1, 16'hFFF0);
        chk("post_rst_theta", theta, {8{8'h01}});
        cyc(1, 0, 0, 16'h0);

        // load beats a gradient beat in IDLE; load in ACCUM is ignored.
        theta_init = {$urandom, $urandom};
        cyc(1, 1, 1, 16'($urandom));
        chk("load_over_beat", theta, theta_init);
        cyc(1, 0, 1, 16'($urandom));
        theta_init = {$urandom, $urandom};
        cyc(1, 1, 1, 16'($urandom));
        for (int k = 2; k < N; k++) cyc(1, 0, 1, 16'($urandom));
        cyc(1, 0, 0, 16'h0);

        // Random traffic on all control inputs.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) theta_init = {$urandom, $urandom};
            cyc($urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0,
                $urandom_range(0, 3) != 0, 16'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mbgd_theta_update.md
MBGD_THETA_UPDATE -- requirements
Module: mbgd_theta_update

Interface
REQ-001 The block SHALL have parameter DW, default 8, theta lane width in bits.
REQ-002 The block SHALL have parameter N, default 8, number of features (theta lanes).
REQ-003 The block SHALL have parameter N_BIT, default 3, giving the lane index width log2(N).
REQ-004 The block SHALL have parameter LR_SHIFT, default 4, giving learning rate alpha = 2^-LR_SHIFT.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port resetn, input, 1 bit: reset, asynchronous and active-high (asserted when 1).
REQ-007 The block SHALL have port enable, input, 1 bit: global run enable.
REQ-008 The block SHALL have port load, input, 1 bit: load theta_init into the theta register.
REQ-009 The block SHALL have port theta_init, input, DW*N bits: initial theta, lane k at bits [DW*k +: DW], signed.
REQ-010 The block SHALL have port g_valid, input, 1 bit: a gradient component is present on g.
REQ-011 The block SHALL have port g, input, 2*DW bits, signed: gradient component for the current lane, from the upstream gradient stage.
REQ-012 The block SHALL have port g_ready, output, 1 bit: the block accepts g this cycle.
REQ-013 The block SHALL have port theta, output, DW*N bits: current theta register, same lane packing as theta_init.
REQ-014 The block SHALL have port theta_valid, output, 1 bit: one-cycle pulse marking a completed update of all N lanes.
REQ-015 The block SHALL have port busy, output, 1 bit: a sweep is partially accepted (FSM in ACCUM).
REQ-016 The block SHALL have port iter_count, output, 16 bits: number of completed sweeps.

Function
REQ-017 A beat SHALL be accepted on a rising edge where g_valid=1, g_ready=1 and enable=1.
REQ-018 g_ready SHALL be 1 only when enable=1 and the FSM is in IDLE or ACCUM.
REQ-019 The FSM SHALL have three states:
- IDLE: accepting lane 0.
- ACCUM: accepting lanes 1..N-1.
- DONE: single cycle, no acceptance.
REQ-020 The FSM SHALL make these transitions on an accepted beat:
- IDLE -> ACCUM, with index set to 1.
- ACCUM: index increments.
- ACCUM -> DONE after the beat at index N-1.
REQ-021 DONE SHALL go to IDLE after one cycle, provided enable=1.
REQ-022 For each accepted beat at index k, theta lane k SHALL update on that same edge to sat_DW(theta[k] - (g >>> LR_SHIFT)).
REQ-023 The shift SHALL be arithmetic, the difference SHALL be computed at 2*DW+1 bits, and the result SHALL clamp to [-2^(DW-1), 2^(DW-1)-1].
REQ-024 theta_valid SHALL be 1 exactly while in DONE, i.e. the cycle after the last-lane beat is accepted; theta SHALL be stable and complete in that cycle.
REQ-025 iter_count SHALL increment by 1 on leaving DONE, wrapping from 0xFFFF to 0.
REQ-026 load=1 in IDLE with enable=1 SHALL copy theta_init into theta on that edge.
REQ-027 load=1 in IDLE SHALL override any g beat in the same cycle; g_ready SHALL be 0 in that cycle.
REQ-028 load SHALL be ignored in ACCUM and DONE.
REQ-029 With enable=0, no register SHALL change and the FSM SHALL hold state, including DONE; theta_valid SHALL stay asserted while held in DONE.
REQ-030 With g_valid=0, the index and theta SHALL hold; the block SHALL impose no timeout.
REQ-031 busy SHALL equal (state == ACCUM).

Reset
REQ-032 While resetn=1, the block SHALL hold these values immediately, independent of clk:
- state = IDLE, index = 0;
- theta, iter_count = 0;
- theta_valid, busy = 0;
- g_ready = 0.
REQ-033 On resetn deassertion, g_ready SHALL follow REQ-018 from the next cycle.
REQ-034 Reset mid-sweep SHALL discard the partial sweep; lanes already updated SHALL also clear to 0.

Structure
REQ-035 Shared package mbgd_pkg SHALL hold the DW, N, N_BIT and LR_SHIFT defaults and the FSM state enum (IDLE, ACCUM, DONE).
REQ-036 One sub-module, mbgd_sat_sub, SHALL implement the combinational shift-subtract-saturate for one lane.
REQ-037 mbgd_theta_update SHALL instantiate mbgd_sat_sub once, muxed by lane index, and SHALL NOT instantiate N copies.

Verification
REQ-038 Basic sweep: load theta=all 0x10; stream g=0x0040 x8 with g_valid held high -> each lane = 0x0C; theta_valid pulses on cycle 9 after the first accept; iter_count=1.
REQ-039 Saturation: load lane0=0x80 (-128); send g=0x7FF0 on lane 0 -> lane0 stays 0x80. Load lane1=0x7F; send g=0x8000 on lane 1 -> lane1 stays 0x7F.
REQ-040 Backpressure: deassert g_valid for 5 cycles after lane 3 -> index holds, busy=1, final theta identical to the unstalled run.
REQ-041 enable low in DONE for 3 cycles -> theta_valid stays high for 4 cycles total; iter_count increments exactly once.
REQ-042 Reset mid-sweep: assert resetn after lane 4 -> theta=0, idle, index=0 asynchronously. Next sweep with g=0xFFF0 x8 -> all lanes = 0x01.
REQ-043 load with g_valid=1 in IDLE -> theta=theta_init, no beat accepted. load during ACCUM -> ignored.
